// File: rtl/led_status_pkg.sv
// Shared types and constants for the board-status LED controller.
package led_status_pkg;

  typedef enum logic [2:0] {
    MODE_OFF       = 3'd0,
    MODE_ON        = 3'd1,
    MODE_HEARTBEAT = 3'd2,
    MODE_ACTIVITY  = 3'd3,
    MODE_BLINK     = 3'd4,
    MODE_DIRECT    = 3'd5
  } led_mode_e;

  // Two short blinks then a pause, indexed by the pattern phase.
  localparam logic [7:0] BlinkPattern = 8'b0000_0101;

endpackage

// File: rtl/led_stretch.sv
// Per-channel activity pulse stretcher: holds active for StretchTicks ticks after activity.
module led_stretch
  import led_status_pkg::*;
#(
  parameter int unsigned StretchTicks = 50
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic activity_i,
  output logic active_o
);

  localparam int unsigned CntW = $clog2(StretchTicks + 1);

  logic [CntW-1:0] st_cnt_d, st_cnt_q;
  logic            active_d, active_q;

  // Load wins over a coincident tick decrement.
  always_comb begin
    st_cnt_d = st_cnt_q;
    if (activity_i) begin
      st_cnt_d = CntW'(StretchTicks);
    end else if (tick_i && (st_cnt_q != '0)) begin
      st_cnt_d = st_cnt_q - CntW'(1);
    end
    active_d = (st_cnt_d != '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_cnt_q <= '0;
      active_q <= 1'b0;
    end else begin
      st_cnt_q <= st_cnt_d;
      active_q <= active_d;
    end
  end

  assign active_o = active_q;

endmodule

// File: rtl/led_status_ctrl.sv
// Board-status LED controller: shared tick/heartbeat/pattern timers, per-LED mode mux and polarity.
module led_status_ctrl
  import led_status_pkg::*;
#(
  parameter int unsigned       NumLeds          = 3,
  parameter int unsigned       TickDiv          = 50_000,
  parameter int unsigned       HbHalfTicks      = 500,
  parameter int unsigned       StretchTicks     = 50,
  parameter int unsigned       PatternStepTicks = 125,
  parameter logic [NumLeds-1:0] LedInvert       = '0
) (
  input  logic                   clk_sys_i,
  input  logic                   rst_sys_ni,
  input  logic [3*NumLeds-1:0]   mode_i,
  input  logic [NumLeds-1:0]     activity_i,
  input  logic [NumLeds-1:0]     direct_i,
  output logic                   tick_o,
  output logic [NumLeds-1:0]     led_o
);

  if (TickDiv < 1) begin : g_chk_tick_div
    $error("TickDiv must be >= 1");
  end
  if (HbHalfTicks < 1) begin : g_chk_hb
    $error("HbHalfTicks must be >= 1");
  end
  if (StretchTicks < 1) begin : g_chk_stretch
    $error("StretchTicks must be >= 1");
  end
  if (PatternStepTicks < 1) begin : g_chk_pat
    $error("PatternStepTicks must be >= 1");
  end

  localparam int unsigned DivW = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam int unsigned HbW  = (HbHalfTicks > 1) ? $clog2(HbHalfTicks) : 1;
  localparam int unsigned PatW = (PatternStepTicks > 1) ? $clog2(PatternStepTicks) : 1;

  logic [DivW-1:0]    div_d, div_q;
  logic [HbW-1:0]     hb_cnt_d, hb_cnt_q;
  logic               hb_d, hb_q;
  logic [PatW-1:0]    pat_cnt_d, pat_cnt_q;
  logic [2:0]         phase_d, phase_q;
  logic               tick;
  logic               tick_d, tick_q;
  logic [NumLeds-1:0] st_active;
  logic [NumLeds-1:0] level;
  logic [NumLeds-1:0] led_d, led_q;
  led_mode_e          mode_sel;

  assign tick = (div_q == DivW'(TickDiv - 1));

  // Shared timebase: divider, heartbeat toggle and blink-pattern phase.
  always_comb begin
    div_d     = tick ? '0 : div_q + DivW'(1);
    hb_cnt_d  = hb_cnt_q;
    hb_d      = hb_q;
    pat_cnt_d = pat_cnt_q;
    phase_d   = phase_q;
    if (tick) begin
      if (hb_cnt_q == HbW'(HbHalfTicks - 1)) begin
        hb_cnt_d = '0;
        hb_d     = ~hb_q;
      end else begin
        hb_cnt_d = hb_cnt_q + HbW'(1);
      end
      if (pat_cnt_q == PatW'(PatternStepTicks - 1)) begin
        pat_cnt_d = '0;
        phase_d   = phase_q + 3'd1;
      end else begin
        pat_cnt_d = pat_cnt_q + PatW'(1);
      end
    end
    tick_d = (div_d == DivW'(TickDiv - 1));
  end

  for (genvar g = 0; g < NumLeds; g++) begin : g_stretch
    led_stretch #(
      .StretchTicks (StretchTicks)
    ) u_stretch (
      .clk_i      (clk_sys_i),
      .rst_ni     (rst_sys_ni),
      .tick_i     (tick),
      .activity_i (activity_i[g]),
      .active_o   (st_active[g])
    );
  end

  // Per-LED mode select; unused encodings fall back to off.
  always_comb begin
    level    = '0;
    mode_sel = MODE_OFF;
    for (int unsigned i = 0; i < NumLeds; i++) begin
      mode_sel = led_mode_e'(mode_i[3*i +: 3]);
      case (mode_sel)
        MODE_ON:        level[i] = 1'b1;
        MODE_HEARTBEAT: level[i] = hb_q;
        MODE_ACTIVITY:  level[i] = activity_i[i] | st_active[i];
        MODE_BLINK:     level[i] = BlinkPattern[phase_q];
        MODE_DIRECT:    level[i] = direct_i[i];
        default:        level[i] = 1'b0;
      endcase
    end
    led_d = level ^ LedInvert;
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      div_q     <= '0;
      hb_cnt_q  <= '0;
      hb_q      <= 1'b0;
      pat_cnt_q <= '0;
      phase_q   <= '0;
      tick_q    <= 1'b0;
      led_q     <= LedInvert;
    end else begin
      div_q     <= div_d;
      hb_cnt_q  <= hb_cnt_d;
      hb_q      <= hb_d;
      pat_cnt_q <= pat_cnt_d;
      phase_q   <= phase_d;
      tick_q    <= tick_d;
      led_q     <= led_d;
    end
  end

  assign tick_o = tick_q;
  assign led_o  = led_q;

endmodule
